// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared constants and state types for the frame stream checker
`timescale 1ns/1ps
package frame_pkg;

  localparam int DW_DEFAULT = 512;

  localparam logic [31:0] MD_SIG_A = 32'hAAAA_AAAA;
  localparam logic [31:0] MD_SIG_B = 32'hBBBB_BBBB;
  localparam logic [31:0] MD_SIG_C = 32'hCCCC_CCCC;
  localparam logic [31:0] MD_SIG_D = 32'hDDDD_DDDD;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } main_state_t;

  typedef enum logic {
    MD_BEAT0,
    MD_BEAT1
  } md_state_t;

endpackage

// File: rtl/frame_md_check.sv
// rtl/frame_md_check.sv - two-beat meta-data record checker with self-resyncing counter
`timescale 1ns/1ps
module frame_md_check
  import frame_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic [DW-1:0] tdata,
  input  logic          fire,
  output logic          err,
  output logic          rec_done
);

  md_state_t     state;
  logic [31:0]   exp_md;
  logic [31:0]   beat0_cnt;
  logic [DW-1:0] exp_beat;

  always_comb begin
    exp_beat        = '0;
    exp_beat[31:0]  = exp_md;
    exp_beat[63:32] = (state == MD_BEAT0) ? MD_SIG_B : MD_SIG_D;
    exp_beat[95:64] = (state == MD_BEAT0) ? MD_SIG_A : MD_SIG_C;
  end

  assign err      = fire && (tdata != exp_beat);
  assign rec_done = fire && (state == MD_BEAT1);

  // exp_md follows the counter actually received in BEAT0, so one bad record costs one record
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= MD_BEAT0;
      exp_md    <= 32'd1;
      beat0_cnt <= '0;
    end else if (restart) begin
      state <= MD_BEAT0;
    end else if (fire) begin
      case (state)
        MD_BEAT0: begin
          beat0_cnt <= tdata[31:0];
          state     <= MD_BEAT1;
        end
        default: begin
          exp_md <= beat0_cnt + 32'd1;
          state  <= MD_BEAT0;
        end
      endcase
    end
  end

endmodule

// File: rtl/frame_check.sv
// rtl/frame_check.sv - frame-data pattern checker, run control and status counters
`timescale 1ns/1ps
module frame_check
  import frame_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [31:0]   frames_expected,
  input  logic [31:0]   FRAME_SIZE,
  input  logic [DW-1:0] AXIS_FD_TDATA,
  input  logic          AXIS_FD_TVALID,
  output logic          AXIS_FD_TREADY,
  input  logic [DW-1:0] AXIS_MD_TDATA,
  input  logic          AXIS_MD_TVALID,
  output logic          AXIS_MD_TREADY,
  output logic          busy,
  output logic          done,
  output logic [31:0]   frames_rcvd,
  output logic [31:0]   fd_errors,
  output logic [31:0]   md_errors,
  output logic [31:0]   first_err_frame
);

  localparam int BYTES_PER_BEAT = DW / 8;

  main_state_t state;
  logic [31:0] exp_frames;
  logic [31:0] bpf;
  logic [31:0] bpf_calc;
  logic [31:0] beat_idx;
  logic [31:0] md_recs;
  logic [15:0] exp_fd;

  logic        start_ok;
  logic        fd_fire;
  logic        md_fire;
  logic        fd_err;
  logic        md_err;
  logic        md_rec_done;
  logic        fd_last;
  logic [31:0] frames_nxt;
  logic [31:0] md_nxt;
  logic [31:0] fd_frame_no;
  logic [31:0] md_frame_no;

  assign start_ok       = start && (state == ST_IDLE) && (frames_expected != 32'd0);
  assign AXIS_FD_TREADY = (state == ST_RUN) && (frames_rcvd < exp_frames);
  assign AXIS_MD_TREADY = (state == ST_RUN) && (md_recs < exp_frames);
  assign fd_fire        = AXIS_FD_TVALID && AXIS_FD_TREADY;
  assign md_fire        = AXIS_MD_TVALID && AXIS_MD_TREADY;
  assign fd_err         = fd_fire && (AXIS_FD_TDATA != {(DW/16){exp_fd}});
  assign fd_last        = fd_fire && (beat_idx == bpf);
  assign frames_nxt     = frames_rcvd + {31'd0, fd_last};
  assign md_nxt         = md_recs + {31'd0, md_rec_done};
  assign fd_frame_no    = frames_rcvd + 32'd1;
  assign md_frame_no    = md_recs + 32'd1;
  assign bpf_calc       = (FRAME_SIZE < BYTES_PER_BEAT) ? 32'd1 : FRAME_SIZE / BYTES_PER_BEAT;

  frame_md_check #(.DW(DW)) u_md (
    .clk      (clk),
    .reset    (reset),
    .restart  (start_ok),
    .tdata    (AXIS_MD_TDATA),
    .fire     (md_fire),
    .err      (md_err),
    .rec_done (md_rec_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      exp_frames      <= '0;
      bpf             <= 32'd1;
      beat_idx        <= 32'd1;
      exp_fd          <= 16'd1;
      frames_rcvd     <= '0;
      md_recs         <= '0;
      fd_errors       <= '0;
      md_errors       <= '0;
      first_err_frame <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state           <= ST_RUN;
            busy            <= 1'b1;
            exp_frames      <= frames_expected;
            bpf             <= bpf_calc;
            beat_idx        <= 32'd1;
            frames_rcvd     <= '0;
            md_recs         <= '0;
            fd_errors       <= '0;
            md_errors       <= '0;
            first_err_frame <= '0;
          end
        end
        ST_RUN: begin
          if (fd_fire) begin
            exp_fd   <= fd_err ? AXIS_FD_TDATA[15:0] + 16'd1 : exp_fd + 16'd1;
            beat_idx <= fd_last ? 32'd1 : beat_idx + 32'd1;
          end
          frames_rcvd <= frames_nxt;
          md_recs     <= md_nxt;
          if (fd_err && (fd_errors != 32'hFFFF_FFFF)) fd_errors <= fd_errors + 32'd1;
          if (md_err && (md_errors != 32'hFFFF_FFFF)) md_errors <= md_errors + 32'd1;
          if (first_err_frame == 32'd0) begin
            if (fd_err && md_err)
              first_err_frame <= (fd_frame_no < md_frame_no) ? fd_frame_no : md_frame_no;
            else if (fd_err)
              first_err_frame <= fd_frame_no;
            else if (md_err)
              first_err_frame <= md_frame_no;
          end
          // look ahead at next-cycle counts so done lands the cycle after the final handshake
          if ((frames_nxt == exp_frames) && (md_nxt == exp_frames)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_check.sv
// tb/tb_frame_check.sv - directed self-checking bench for frame_check
`timescale 1ns/1ps
module tb_frame_check;

  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   frames_exp = '0;
  logic [31:0]   frame_size = 32'd256;
  logic [DW-1:0] fd_data = '0;
  logic          fd_valid = 1'b0;
  logic          fd_ready;
  logic [DW-1:0] md_data = '0;
  logic          md_valid = 1'b0;
  logic          md_ready;
  logic          busy;
  logic          done;
  logic [31:0]   frames_rcvd;
  logic [31:0]   fd_errors;
  logic [31:0]   md_errors;
  logic [31:0]   first_err_frame;

  int checks = 0;
  int errors = 0;
  int done_total = 0;
  int done_base = 0;

  always #5 clk = ~clk;

  frame_check #(.DW(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .frames_expected (frames_exp),
    .FRAME_SIZE      (frame_size),
    .AXIS_FD_TDATA   (fd_data),
    .AXIS_FD_TVALID  (fd_valid),
    .AXIS_FD_TREADY  (fd_ready),
    .AXIS_MD_TDATA   (md_data),
    .AXIS_MD_TVALID  (md_valid),
    .AXIS_MD_TREADY  (md_ready),
    .busy            (busy),
    .done            (done),
    .frames_rcvd     (frames_rcvd),
    .fd_errors       (fd_errors),
    .md_errors       (md_errors),
    .first_err_frame (first_err_frame)
  );

  always @(negedge clk) if (done === 1'b1) done_total++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_fd(input logic [DW-1:0] d, input bit rnd);
    bit hs = 1'b0;
    if (rnd) while ($urandom_range(0, 1) == 0) begin fd_valid = 1'b0; @(negedge clk); end
    fd_data  = d;
    fd_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (fd_ready) begin hs = 1'b1; @(negedge clk); break; end
      @(negedge clk);
    end
    if (!hs) check("fd_timeout", 32'(hs), 32'd1);
  endtask

  task automatic push_md(input logic [DW-1:0] d, input bit rnd);
    bit hs = 1'b0;
    if (rnd) while ($urandom_range(0, 1) == 0) begin md_valid = 1'b0; @(negedge clk); end
    md_data  = d;
    md_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (md_ready) begin hs = 1'b1; @(negedge clk); break; end
      @(negedge clk);
    end
    if (!hs) check("md_timeout", 32'(hs), 32'd1);
  endtask

  task automatic send_fd(input int n, input logic [15:0] w0, input int bad, input bit rnd);
    logic [DW-1:0] d;
    logic [15:0]   w;
    for (int b = 1; b <= n; b++) begin
      w = w0 + 16'(b - 1);
      d = {(DW/16){w}};
      if (b == bad) d[5*16 +: 16] = 16'h0106;
      push_fd(d, rnd);
    end
    fd_valid = 1'b0;
  endtask

  task automatic send_md(input int n, input logic [31:0] c0, input int bad, input bit rnd);
    logic [DW-1:0] d;
    for (int r = 1; r <= n; r++) begin
      d = '0;
      d[95:0] = {32'hAAAA_AAAA, 32'hBBBB_BBBB, c0 + 32'(r - 1)};
      push_md(d, rnd);
      d[95:0] = {32'hCCCC_CCCC, 32'hDDDD_DDDD, c0 + 32'(r - 1)};
      if (r == bad) d[95:64] = 32'hCCCC_CCCD;
      push_md(d, rnd);
    end
    md_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] fe);
    start      = 1'b1;
    frames_exp = fe;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input int fe, input logic [15:0] w0, input logic [31:0] c0,
                     input int fd_bad, input int md_bad, input bit rnd);
    done_base = done_total;
    pulse_start(32'(fe));
    check("busy_after_start", 32'(busy), 32'd1);
    fork
      send_fd(fe * 4, w0, fd_bad, rnd);
      send_md(fe, c0, md_bad, rnd);
    join
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_fd_ready", 32'(fd_ready), 32'd0);
    check("rst_md_ready", 32'(md_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_frames", frames_rcvd, 32'd0);
    check("rst_first_err", first_err_frame, 32'd0);

    // clean run
    run(3, 16'h0001, 32'd1, 0, 0, 1'b0);
    check("clean_frames", frames_rcvd, 32'd3);
    check("clean_fd_err", fd_errors, 32'd0);
    check("clean_md_err", md_errors, 32'd0);
    check("clean_first", first_err_frame, 32'd0);
    check("clean_done_cnt", 32'(done_total - done_base), 32'd1);
    check("clean_busy_low", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("clean_frames_hold", frames_rcvd, 32'd3);

    // frame-data corruption at beat 6, lane 5
    do_reset();
    run(3, 16'h0001, 32'd1, 6, 0, 1'b0);
    check("fdc_fd_err", fd_errors, 32'd1);
    check("fdc_first", first_err_frame, 32'd2);
    check("fdc_md_err", md_errors, 32'd0);
    check("fdc_frames", frames_rcvd, 32'd3);

    // meta-data corruption in frame 2 BEAT1
    do_reset();
    run(3, 16'h0001, 32'd1, 0, 2, 1'b0);
    check("mdc_md_err", md_errors, 32'd1);
    check("mdc_first", first_err_frame, 32'd2);
    check("mdc_fd_err", fd_errors, 32'd0);
    check("mdc_done_cnt", 32'(done_total - done_base), 32'd1);

    // backpressure, then continuity into a second run
    do_reset();
    run(3, 16'h0001, 32'd1, 0, 0, 1'b1);
    check("bp_frames", frames_rcvd, 32'd3);
    check("bp_fd_err", fd_errors, 32'd0);
    check("bp_md_err", md_errors, 32'd0);
    check("bp_done_cnt", 32'(done_total - done_base), 32'd1);
    check("idle_fd_ready", 32'(fd_ready), 32'd0);
    check("idle_md_ready", 32'(md_ready), 32'd0);
    run(2, 16'h000D, 32'd4, 0, 0, 1'b1);
    check("cont_frames", frames_rcvd, 32'd2);
    check("cont_fd_err", fd_errors, 32'd0);
    check("cont_md_err", md_errors, 32'd0);
    check("cont_first", first_err_frame, 32'd0);

    // reset during frame 2, beat 3
    do_reset();
    pulse_start(32'd3);
    fork
      send_fd(6, 16'h0001, 0, 1'b0);
      send_md(1, 32'd1, 0, 1'b0);
    join
    fd_data  = {(DW/16){16'h0007}};
    fd_valid = 1'b1;
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    fd_valid = 1'b0;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_fd_ready", 32'(fd_ready), 32'd0);
    check("mid_md_ready", 32'(md_ready), 32'd0);
    check("mid_frames", frames_rcvd, 32'd0);
    check("mid_fd_err", fd_errors, 32'd0);
    run(3, 16'h0001, 32'd1, 0, 0, 1'b0);
    check("post_rst_frames", frames_rcvd, 32'd3);
    check("post_rst_fd_err", fd_errors, 32'd0);
    check("post_rst_md_err", md_errors, 32'd0);

    // start with zero frames is ignored
    pulse_start(32'd0);
    check("zero_start_busy", 32'(busy), 32'd0);
    check("zero_start_frames", frames_rcvd, 32'd3);

    // start while busy does not re-latch frames_expected
    done_base = done_total;
    pulse_start(32'd2);
    pulse_start(32'd5);
    fork
      send_fd(8, 16'h000D, 0, 1'b0);
      send_md(2, 32'd4, 0, 1'b0);
    join
    repeat (3) @(negedge clk);
    check("busy_start_done", 32'(done_total - done_base), 32'd1);
    check("busy_start_frames", frames_rcvd, 32'd2);
    check("busy_start_fd_err", fd_errors, 32'd0);
    check("busy_start_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
